timer_cc_unit: RTL and testbench
================================

// Module: timer_cc_unit
// PURPOSE
//  Next-generation time base: prescaled auto-reload counter, up/down, one-pulse mode.
//  Adds NUM_CH compare channels with match pulses and PWM outputs.
//  Sits between the timer register file and the pin mux.
//  Drives the update event (uev) to the interrupt/DMA logic.
// PARAMETERS
//  BITS_WIDTH  32  counter, prescaler, reload and compare width
//  NUM_CH      4   number of compare channels (1..8)
// PORTS
//  clk       in   1               system clock, rising edge
//  n_rst     in   1               asynchronous active-low reset
//  tc_en     in   1               count enable (gates the prescaler)
//  tc_rst    in   1               synchronous counter reset; priority over tc_en
//  dir       in   1               0 = up, 1 = down (timer_pkg::cnt_dir_t)
//  opm       in   1               one-pulse mode
//  tarr      in   BITS_WIDTH      auto-reload value
//  tpsc      in   BITS_WIDTH      prescale; tick every tpsc+1 enabled cycles
//  ccr       in   NUM_CH*BW       compare values; ch i = [i*BW +: BW]
//  cc_pol    in   NUM_CH          PWM polarity; 1 inverts pwm_out[i]
//  tcnt      out  BITS_WIDTH      current count (registered)
//  nxt_tcnt  out  BITS_WIDTH      value tcnt takes at the next clk edge (combinational)
//  uev       out  1               update event; 1-cycle pulse on wrap
//  cc_match  out  NUM_CH          1-cycle pulse when tcnt becomes ccr[i]
//  pwm_out   out  NUM_CH          registered PWM
//  running   out  1               tc_en and not halted by one-pulse mode
// BEHAVIOUR
//  Reset (n_rst=0):
//  - Async clear: tcnt, psc_cnt, uev, cc_match, pwm_out, opm_halt = 0.
//  Prescaler:
//  - psc_cnt counts 0..tpsc while running; tick = running && psc_cnt==tpsc.
//  - psc_cnt wraps to 0 on tick. tpsc=0 gives a tick every cycle.
//  Up count (dir=0):
//  - On tick, tcnt >= arr -> tcnt<=0 and uev; else tcnt+1.
//  - Lowering arr below tcnt gives a wrap on the next tick; the counter never overflows.
//  Down count (dir=1):
//  - On tick, tcnt==0 -> tcnt<=arr and uev; else tcnt-1.
//  arr=0: tcnt stays 0 and uev fires on every tick.
//  tc_rst=1 on a clock edge:
//  - tcnt<=0 (up) or arr (down); psc_cnt<=0; opm_halt<=0; no uev/cc_match.
//  tc_en=0: tcnt and psc_cnt hold; outputs hold; uev/cc_match stay 0.
//  dir change mid-count: applied on the next tick from the current tcnt; no uev.
//  One-pulse mode:
//  - opm=1 and uev -> opm_halt<=1, so running=0 and the counter freezes at the wrap value.
//  - Cleared by tc_rst or by tc_en=0.
//  Compare, per channel i:
//  - cc_match[i] <= tick && nxt_tcnt==ccr[i].
//  - pwm_out[i] <= (nxt_tcnt < ccr[i]) ^ cc_pol[i].
//  - ccr > arr gives a constant 1 (pol=0); ccr=0 gives a constant 0.
//  Latency:
//  - uev, cc_match and pwm_out align with the tcnt update (same edge).
//  - Inputs are sampled on the edge they affect.
// CONFIGURATION
//  TIMER_PRELOAD_EN defined:
//  - arr and ccr come from shadow registers, loaded from tarr/ccr on uev, tc_rst, and the first cycle after reset.
//  - Shadows reset to 0. Writes mid-period take effect at the next period.
//  TIMER_PRELOAD_EN undefined:
//  - tarr/ccr are used directly and take effect on the next tick.
// STRUCTURE
//  timer_pkg:
//  - cnt_dir_t enum {DIR_UP, DIR_DOWN}.
//  - localparam MAX_CH = 8.
//  - function cc_slice(vec, i) for ccr unpacking.
//  Sub-module timer_prescaler (psc_cnt, tick); channels built with a generate loop.
// TESTING (BITS_WIDTH=32, NUM_CH=4)
//  1. tarr=5, tpsc=0, up, tc_en=1 after reset
//     -> tcnt 0..5,0; uev 1 cycle at each 5->0; nxt_tcnt leads tcnt by one cycle.
//  2. tarr=50, tpsc=1
//     -> tcnt changes every 2nd cycle; first uev 102 cycles after enable; tc_en=0 for 2 cycles holds tcnt.
//  3. dir=1, tarr=10, tc_rst pulse
//     -> tcnt=10, counts down to 0, reloads 10 with uev.
//     -> dir flip at tcnt=4 gives 5 on the next tick.
//  4. opm=1, tarr=3
//     -> single uev; tcnt holds 0 and running=0.
//     -> tc_rst restarts; tc_en=0 then 1 also restarts.
//  5. tarr=9, ccr={12,0,3,9}, cc_pol=4'b0010
//     -> pwm ch2 high for tcnt 0..2; ch0 always 1; ch1 always 1 (inverted 0).
//     -> cc_match[3] pulses once per period.
//  6. PRELOAD_EN: tarr 9->4 written at tcnt=2
//     -> current period wraps at 9, next at 4.
//     -> without the macro it wraps at 4 immediately; n_rst mid-count clears all outputs asynchronously.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer/compare unit.
package timer_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } cnt_dir_t;

    localparam int unsigned MAX_CH = 8;
    localparam int unsigned MAX_BW = 64;

    // Extract channel idx (bw bits wide) from a zero-extended packed compare vector.
    function automatic logic [MAX_BW-1:0] cc_slice(input logic [MAX_CH*MAX_BW-1:0] vec,
                                                   input int unsigned idx,
                                                   input int unsigned bw);
        logic [MAX_BW-1:0] r_val;
        r_val = MAX_BW'(vec >> (idx * bw));
        for (int b = 0; b < MAX_BW; b++) begin
            if (b >= int'(bw)) begin
                r_val[b[5:0]] = 1'b0;
            end
        end
        return r_val;
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..tpsc while running and emits a tick on the terminal count.
module timer_prescaler #(
    parameter int unsigned BITS_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_run,
    input  logic                  i_clr,
    input  logic [BITS_WIDTH-1:0] i_tpsc,
    output logic                  o_tick
);

    localparam logic [BITS_WIDTH-1:0] ONE = BITS_WIDTH'(1);

    logic [BITS_WIDTH-1:0] r_psc_cnt;

    assign o_tick = i_run && (r_psc_cnt == i_tpsc);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_psc_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_psc_cnt <= '0;
        end else if (i_run) begin
            r_psc_cnt <= r_psc_cnt + ONE;
        end
    end

endmodule

// File: rtl/timer_cc_unit.sv
// Prescaled up/down auto-reload timer with one-pulse mode and NUM_CH compare/PWM channels.
// Define TIMER_PRELOAD_EN to take arr/ccr from shadow registers updated at period boundaries.
module timer_cc_unit
    import timer_pkg::*;
#(
    parameter int unsigned BITS_WIDTH = 32,
    parameter int unsigned NUM_CH     = 4
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         tc_en,
    input  logic                         tc_rst,
    input  logic                         dir,
    input  logic                         opm,
    input  logic [BITS_WIDTH-1:0]        tarr,
    input  logic [BITS_WIDTH-1:0]        tpsc,
    input  logic [NUM_CH*BITS_WIDTH-1:0] ccr,
    input  logic [NUM_CH-1:0]            cc_pol,
    output logic [BITS_WIDTH-1:0]        tcnt,
    output logic [BITS_WIDTH-1:0]        nxt_tcnt,
    output logic                         uev,
    output logic [NUM_CH-1:0]            cc_match,
    output logic [NUM_CH-1:0]            pwm_out,
    output logic                         running
);

    localparam logic [BITS_WIDTH-1:0] ONE = BITS_WIDTH'(1);

    logic [BITS_WIDTH-1:0]        r_tcnt;
    logic                         r_uev;
    logic                         r_halt;
    logic                         w_running;
    logic                         w_tick;
    logic                         w_tick_ok;
    logic                         w_wrap;
    logic                         w_down;
    logic [BITS_WIDTH-1:0]        w_nxt;
    logic [BITS_WIDTH-1:0]        w_arr;
    logic [NUM_CH*BITS_WIDTH-1:0] w_ccr_vec;
    logic [MAX_CH*MAX_BW-1:0]     w_ccr_ext;

    assign w_running = tc_en && !r_halt;
    assign w_down    = (cnt_dir_t'(dir) == DIR_DOWN);
    assign w_tick_ok = w_tick && !tc_rst;

    timer_prescaler #(
        .BITS_WIDTH(BITS_WIDTH)
    ) u_psc (
        .clk   (clk),
        .n_rst (n_rst),
        .i_run (w_running),
        .i_clr (tc_rst),
        .i_tpsc(tpsc),
        .o_tick(w_tick)
    );

`ifdef TIMER_PRELOAD_EN
    logic                         r_first;
    logic [BITS_WIDTH-1:0]        r_arr_sh;
    logic [NUM_CH*BITS_WIDTH-1:0] r_ccr_sh;
    logic                         w_load;

    // The first cycle out of reset sees the incoming values, so period one is not cut short.
    assign w_load    = r_first || tc_rst || w_wrap;
    assign w_arr     = r_first ? tarr : r_arr_sh;
    assign w_ccr_vec = w_load ? ccr : r_ccr_sh;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_first  <= 1'b1;
            r_arr_sh <= '0;
            r_ccr_sh <= '0;
        end else begin
            r_first <= 1'b0;
            if (w_load) begin
                r_arr_sh <= tarr;
                r_ccr_sh <= ccr;
            end
        end
    end
`else
    assign w_arr     = tarr;
    assign w_ccr_vec = ccr;
`endif

    always_comb begin
        w_ccr_ext                          = '0;
        w_ccr_ext[NUM_CH*BITS_WIDTH-1:0] = w_ccr_vec;
    end

    // Down reload uses tarr directly: with preload on, the shadow is being loaded with it anyway.
    always_comb begin
        w_wrap = 1'b0;
        w_nxt  = r_tcnt;
        if (tc_rst) begin
            w_nxt = w_down ? tarr : '0;
        end else if (w_tick) begin
            if (w_down) begin
                if (r_tcnt == '0) begin
                    w_nxt  = tarr;
                    w_wrap = 1'b1;
                end else begin
                    w_nxt = r_tcnt - ONE;
                end
            end else begin
                if (r_tcnt >= w_arr) begin
                    w_nxt  = '0;
                    w_wrap = 1'b1;
                end else begin
                    w_nxt = r_tcnt + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tcnt <= '0;
            r_uev  <= 1'b0;
            r_halt <= 1'b0;
        end else begin
            r_tcnt <= w_nxt;
            r_uev  <= w_wrap;
            if (tc_rst || !tc_en) begin
                r_halt <= 1'b0;
            end else if (w_wrap && opm) begin
                r_halt <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [BITS_WIDTH-1:0] w_ccr_ch;
        logic                  r_match;
        logic                  r_pwm;

        assign w_ccr_ch = BITS_WIDTH'(cc_slice(w_ccr_ext, g, BITS_WIDTH));

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                r_match <= 1'b0;
                r_pwm   <= 1'b0;
            end else begin
                r_match <= w_tick_ok && (w_nxt == w_ccr_ch);
                if (tc_en || tc_rst) begin
                    r_pwm <= (w_nxt < w_ccr_ch) ^ cc_pol[g];
                end
            end
        end

        assign cc_match[g] = r_match;
        assign pwm_out[g]  = r_pwm;
    end

    assign tcnt     = r_tcnt;
    assign nxt_tcnt = w_nxt;
    assign uev      = r_uev;
    assign running  = w_running;

endmodule

// File: tb/tb_timer_cc_unit.sv
// Self-checking bench for timer_cc_unit: directed scenarios plus randomized run vs a reference model.
module tb_timer_cc_unit;

    logic         clk = 1'b0;
    logic         n_rst, tc_en, tc_rst, dir, opm;
    logic [31:0]  tarr, tpsc;
    logic [127:0] ccr;
    logic [3:0]   cc_pol;
    logic [31:0]  tcnt, nxt_tcnt;
    logic         uev, running;
    logic [3:0]   cc_match, pwm_out;

    int n_cmp = 0;
    int n_fail = 0;

    timer_cc_unit #(.BITS_WIDTH(32), .NUM_CH(4)) dut (
        .clk(clk), .n_rst(n_rst), .tc_en(tc_en), .tc_rst(tc_rst), .dir(dir), .opm(opm),
        .tarr(tarr), .tpsc(tpsc), .ccr(ccr), .cc_pol(cc_pol), .tcnt(tcnt),
        .nxt_tcnt(nxt_tcnt), .uev(uev), .cc_match(cc_match), .pwm_out(pwm_out),
        .running(running)
    );

    always #5 clk = ~clk;

    // Reference model state (m_) and its predicted next state (p_).
    int unsigned m_tcnt, m_psc, m_arr_sh, p_tcnt, p_psc, p_arr_sh;
    int unsigned m_ccr_sh[4], p_ccr_sh[4];
    bit          m_halt, m_uev, m_first, p_halt, p_uev, p_first;
    bit [3:0]    m_match, m_pwm, p_match, p_pwm;

    function automatic int unsigned ccr_in(int i);
        return ccr[i*32 +: 32];
    endfunction

    task automatic model_reset();
        m_tcnt = 0; m_psc = 0; m_arr_sh = 0; m_halt = 0; m_uev = 0; m_first = 1;
        m_match = '0; m_pwm = '0;
        for (int i = 0; i < 4; i++) m_ccr_sh[i] = 0;
    endtask

    task automatic model_predict();
        bit run, tick, wrap, load;
        int unsigned arr, c;
        run  = tc_en && !m_halt;
        tick = run && (m_psc == tpsc);
        wrap = 0;
`ifdef TIMER_PRELOAD_EN
        arr = m_first ? tarr : m_arr_sh;
`else
        arr = tarr;
`endif
        p_tcnt = m_tcnt;
        p_halt = m_halt;
        if (tc_rst) begin
            p_tcnt = dir ? tarr : 0;
            p_psc  = 0;
            p_halt = 0;
        end else begin
            p_psc = tick ? 0 : (run ? m_psc + 1 : m_psc);
            if (tick && !dir) begin
                if (m_tcnt >= arr) begin p_tcnt = 0; wrap = 1; end
                else p_tcnt = m_tcnt + 1;
            end else if (tick && dir) begin
                if (m_tcnt == 0) begin p_tcnt = tarr; wrap = 1; end
                else p_tcnt = m_tcnt - 1;
            end
            if (!tc_en) p_halt = 0;
            else if (wrap && opm) p_halt = 1;
        end
        p_uev   = wrap;
        load    = m_first || tc_rst || wrap;
        p_first = 0;
        p_arr_sh = load ? tarr : m_arr_sh;
        for (int i = 0; i < 4; i++) begin
`ifdef TIMER_PRELOAD_EN
            c = load ? ccr_in(i) : m_ccr_sh[i];
`else
            c = ccr_in(i);
`endif
            p_ccr_sh[i] = load ? ccr_in(i) : m_ccr_sh[i];
            p_match[i]  = tick && !tc_rst && (p_tcnt == c);
            p_pwm[i]    = (tc_en || tc_rst) ? ((p_tcnt < c) ^ cc_pol[i]) : m_pwm[i];
        end
    endtask

    task automatic model_commit();
        m_tcnt = p_tcnt; m_psc = p_psc; m_halt = p_halt; m_uev = p_uev; m_first = p_first;
        m_arr_sh = p_arr_sh; m_match = p_match; m_pwm = p_pwm;
        for (int i = 0; i < 4; i++) m_ccr_sh[i] = p_ccr_sh[i];
    endtask

    task automatic advance();
        model_predict();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        tc_rst = 1'b1;
        advance();
        tc_rst = 1'b0;
    endtask

    function automatic logic [41:0] dut_vec();
        return {tcnt, uev, cc_match, pwm_out, running};
    endfunction

    function automatic logic [41:0] mdl_vec();
        return {m_tcnt, m_uev, m_match, m_pwm, tc_en && !m_halt};
    endfunction

    task automatic test_reset();
        n_rst = 1'b0; tc_en = 0; tc_rst = 0; dir = 0; opm = 0;
        tarr = 0; tpsc = 0; ccr = '0; cc_pol = '0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({tcnt, nxt_tcnt, uev, cc_match, pwm_out, running} !== 75'd0) begin
            n_fail++;
            $display("FAIL reset_state: got tcnt=%0d nxt=%0d uev=%b m=%b pwm=%b run=%b want all 0",
                     tcnt, nxt_tcnt, uev, cc_match, pwm_out, running);
        end
        n_rst = 1'b1;
    endtask

    task automatic test_up_basic();
        tarr = 5; tpsc = 0; dir = 0; tc_en = 1;
        for (int k = 1; k <= 13; k++) begin
            #1;
            n_cmp++;
            if (nxt_tcnt !== 32'(k % 6)) begin
                n_fail++;
                $display("FAIL up_nxt k=%0d: got %0d want %0d", k, nxt_tcnt, k % 6);
            end
            advance();
            n_cmp++;
            if ({tcnt, uev} !== {32'(k % 6), k % 6 == 0}) begin
                n_fail++;
                $display("FAIL up_seq k=%0d: got tcnt=%0d uev=%b want %0d/%b",
                         k, tcnt, uev, k % 6, k % 6 == 0);
            end
        end
    endtask

    task automatic test_prescale();
        int first;
        int unsigned held;
        tarr = 50; tpsc = 1; dir = 0; tc_en = 0;
        pulse_rst();
        tc_en = 1;
        first = -1;
        for (int c = 1; c <= 300; c++) begin
            advance();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL psc_model c=%0d: got %h want %h", c, dut_vec(), mdl_vec());
            end
            if (uev) begin first = c; break; end
        end
        n_cmp++;
        if (first != 102) begin
            n_fail++;
            $display("FAIL psc_first_uev: got %0d cycles want 102", first);
        end
        advance(); advance(); advance();
        held = tcnt;
        tc_en = 0;
        advance(); advance();
        n_cmp++;
        if ({tcnt, uev} !== {held, 1'b0}) begin
            n_fail++;
            $display("FAIL psc_hold: got tcnt=%0d uev=%b want %0d/0", tcnt, uev, held);
        end
        tc_en = 1;
    endtask

    task automatic test_down();
        int guard;
        tarr = 10; tpsc = 0; dir = 1; tc_en = 1; opm = 0;
        pulse_rst();
        n_cmp++;
        if (tcnt !== 32'd10) begin
            n_fail++;
            $display("FAIL down_rst: got %0d want 10", tcnt);
        end
        for (int k = 1; k <= 11; k++) begin
            advance();
            n_cmp++;
            if ({tcnt, uev} !== {(k <= 10) ? 32'(10 - k) : 32'd10, k == 11}) begin
                n_fail++;
                $display("FAIL down_seq k=%0d: got tcnt=%0d uev=%b", k, tcnt, uev);
            end
        end
        guard = 0;
        while (tcnt != 4 && guard < 20) begin advance(); guard++; end
        dir = 0;
        advance();
        n_cmp++;
        if ({tcnt, uev} !== {32'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL dir_flip: got tcnt=%0d uev=%b want 5/0", tcnt, uev);
        end
    endtask

    task automatic test_one_pulse();
        int n_uev;
        tarr = 3; tpsc = 0; dir = 0; opm = 1; tc_en = 1;
        pulse_rst();
        n_uev = 0;
        for (int k = 0; k < 9; k++) begin advance(); n_uev += int'(uev); end
        n_cmp++;
        if ({n_uev, tcnt, running} !== {32'd1, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL opm_halt: got uevs=%0d tcnt=%0d run=%b want 1/0/0",
                     n_uev, tcnt, running);
        end
        pulse_rst();
        advance();
        n_cmp++;
        if ({tcnt, running} !== {32'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL opm_rst_restart: got tcnt=%0d run=%b want 1/1", tcnt, running);
        end
        repeat (3) advance();
        tc_en = 0;
        advance();
        tc_en = 1;
        advance();
        n_cmp++;
        if ({tcnt, running} !== {32'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL opm_en_restart: got tcnt=%0d run=%b want 1/1", tcnt, running);
        end
        opm = 0;
    endtask

    task automatic test_compare();
        int n_m3;
        tarr = 9; tpsc = 0; dir = 0; opm = 0; tc_en = 1;
        ccr = {32'd9, 32'd3, 32'd0, 32'd12};
        cc_pol = 4'b0010;
        pulse_rst();
        n_m3 = 0;
        for (int k = 0; k < 30; k++) begin
            advance();
            n_m3 += int'(cc_match[3]);
            n_cmp++;
            if ({pwm_out, cc_match} !== {tcnt < 9, tcnt < 3, 1'b1, 1'b1,
                                         tcnt == 9, tcnt == 3, tcnt == 0, 1'b0}) begin
                n_fail++;
                $display("FAIL cmp_pwm tcnt=%0d: got pwm=%b m=%b", tcnt, pwm_out, cc_match);
            end
        end
        n_cmp++;
        if (n_m3 != 3) begin
            n_fail++;
            $display("FAIL cmp_match3_count: got %0d want 3", n_m3);
        end
    endtask

    task automatic test_preload();
        int unsigned peak1, peak2, want1;
        tarr = 9; tpsc = 0; dir = 0; opm = 0; tc_en = 1;
        pulse_rst();
        advance(); advance();
        tarr = 4;
        peak1 = tcnt;
        for (int k = 0; k < 40; k++) begin
            advance();
            if (uev) break;
            if (tcnt > peak1) peak1 = tcnt;
        end
        peak2 = 0;
        for (int k = 0; k < 40; k++) begin
            advance();
            if (uev) break;
            if (tcnt > peak2) peak2 = tcnt;
        end
`ifdef TIMER_PRELOAD_EN
        want1 = 9;
`else
        want1 = 4;
`endif
        n_cmp++;
        if ({peak1, peak2} !== {want1, 32'd4}) begin
            n_fail++;
            $display("FAIL preload_wrap: got peaks %0d,%0d want %0d,4", peak1, peak2, want1);
        end
        advance(); advance();
        #2 n_rst = 1'b0;
        #1;
        n_cmp++;
        if ({tcnt, uev, cc_match, pwm_out} !== 41'd0) begin
            n_fail++;
            $display("FAIL async_reset: got tcnt=%0d uev=%b m=%b pwm=%b want 0",
                     tcnt, uev, cc_match, pwm_out);
        end
        model_reset();
        tc_en = 0;
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    task automatic test_random();
        tc_en = 1; tc_rst = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                tc_rst = 1;
                tpsc   = $urandom_range(0, 3);
            end else begin
                tc_rst = 0;
            end
            tc_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 31) == 0) opm = ~opm;
            if ($urandom_range(0, 7) == 0) tarr = $urandom_range(0, 12);
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) == 0) ccr[i*32 +: 32] = $urandom_range(0, 14);
            if ($urandom_range(0, 31) == 0) cc_pol = 4'($urandom_range(0, 15));
            #1;
            model_predict();
            n_cmp++;
            if (nxt_tcnt !== p_tcnt) begin
                n_fail++;
                $display("FAIL rnd_nxt c=%0d: got %0d want %0d", c, nxt_tcnt, p_tcnt);
            end
            advance();
            n_cmp++;
            if (dut_vec() !== mdl_vec()) begin
                n_fail++;
                $display("FAIL rnd_state c=%0d: got %h want %h", c, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_up_basic();
        test_prescale();
        test_down();
        test_one_pulse();
        test_compare();
        test_preload();
        tarr = 7; tpsc = 0; tc_en = 1;
        pulse_rst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
